// File: rtl/ysyx_22040632_tag_array_assoc.sv
// ysyx_22040632_tag_array_assoc: N-way set-associative dcache tag store with true-LRU victim selection and a dirty-line flush engine
module ysyx_22040632_tag_array_assoc #(
  parameter int WAYS  = 4,
  parameter int SETS  = 32,
  parameter int TAG_W = 21,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] req_set,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             lookup_en,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic             hit_dirty,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_valid,
  output logic             victim_dirty,
  output logic [TAG_W-1:0] victim_tag,
  input  logic             wr_en,
  input  logic [WAY_W-1:0] wr_way,
  input  logic             wr_dirty,
  input  logic             mark_dirty_en,
  input  logic [WAY_W-1:0] mark_way,
  input  logic             flush_req,
  output logic             busy,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [IDX_W-1:0] wb_set,
  output logic [WAY_W-1:0] wb_way,
  output logic [TAG_W-1:0] wb_tag,
  output logic             flush_done
);
  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;
  state_t state_q, state_d;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-1:0] dirty_d [SETS];
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_d [SETS][WAYS];
  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];
  logic [IDX_W-1:0] ptr_set_q, ptr_set_d, wb_set_q, wb_set_d;
  logic [WAY_W-1:0] ptr_way_q, ptr_way_d, wb_way_q, wb_way_d;
  logic [WAY_W-1:0] hit_idx, inv_way, lru_way, touch_way;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic busy_q, busy_d, wb_valid_q, wb_valid_d, flush_done_q, flush_done_d;
  logic any_hit, any_inv, last, line_dirty, retire;

  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    any_inv = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        any_hit = 1'b1;
        hit_idx = WAY_W'(w);
      end
      if (!valid_q[req_set][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[req_set][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
  end

  assign hit          = any_hit & ~busy_q;
  assign hit_way      = hit ? hit_idx : '0;
  assign hit_dirty    = hit & dirty_q[req_set][hit_idx];
  assign victim_way   = any_inv ? inv_way : lru_way;
  assign victim_valid = valid_q[req_set][victim_way];
  assign victim_dirty = dirty_q[req_set][victim_way];
  assign victim_tag   = tag_q[req_set][victim_way];
  assign busy         = busy_q;
  assign wb_valid     = wb_valid_q;
  assign wb_set       = wb_set_q;
  assign wb_way       = wb_way_q;
  assign wb_tag       = wb_tag_q;
  assign flush_done   = flush_done_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    age_d        = age_q;
    ptr_set_d    = ptr_set_q;
    ptr_way_d    = ptr_way_q;
    wb_valid_d   = wb_valid_q;
    wb_set_d     = wb_set_q;
    wb_way_d     = wb_way_q;
    wb_tag_d     = wb_tag_q;
    flush_done_d = 1'b0;
    touch_way    = wr_en ? wr_way : mark_dirty_en ? mark_way : hit_idx;
    last         = &ptr_set_q && &ptr_way_q;
    line_dirty   = valid_q[ptr_set_q][ptr_way_q] && dirty_q[ptr_set_q][ptr_way_q];
    retire       = (state_q == SCAN && !line_dirty) || (state_q == WB && wb_ready);
    if (state_q == IDLE) begin
      if (wr_en) begin
        valid_d[req_set][wr_way] = 1'b1;
        dirty_d[req_set][wr_way] = wr_dirty;
        tag_d[req_set][wr_way]   = req_tag;
      end
      if (mark_dirty_en) dirty_d[req_set][mark_way] = 1'b1;
      if (wr_en || mark_dirty_en || (lookup_en && hit))
        for (int w = 0; w < WAYS; w++)
          age_d[req_set][w] = WAY_W'(w) == touch_way ? '0 :
                              age_q[req_set][w] < age_q[req_set][touch_way] ? age_q[req_set][w] + WAY_W'(1) :
                              age_q[req_set][w];
      if (flush_req) begin
        state_d   = SCAN;
        ptr_set_d = '0;
        ptr_way_d = '0;
      end
    end
    if (state_q == SCAN && line_dirty) begin
      state_d    = WB;
      wb_valid_d = 1'b1;
      wb_set_d   = ptr_set_q;
      wb_way_d   = ptr_way_q;
      wb_tag_d   = tag_q[ptr_set_q][ptr_way_q];
    end
    if (retire) begin
      valid_d[ptr_set_q][ptr_way_q] = 1'b0;
      dirty_d[ptr_set_q][ptr_way_q] = 1'b0;
      wb_valid_d                    = 1'b0;
      state_d                       = last ? DONE : SCAN;
      flush_done_d                  = last;
      ptr_way_d                     = ptr_way_q + WAY_W'(1);
      ptr_set_d                     = ptr_set_q + IDX_W'(&ptr_way_q);
    end
    if (state_q == DONE) begin
      state_d = IDLE;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_d[s][w] = WAY_W'(w);
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_set_q    <= '0;
      ptr_way_q    <= '0;
      busy_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_set_q     <= '0;
      wb_way_q     <= '0;
      wb_tag_q     <= '0;
      flush_done_q <= 1'b0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
    end else begin
      state_q      <= state_d;
      ptr_set_q    <= ptr_set_d;
      ptr_way_q    <= ptr_way_d;
      busy_q       <= busy_d;
      wb_valid_q   <= wb_valid_d;
      wb_set_q     <= wb_set_d;
      wb_way_q     <= wb_way_d;
      wb_tag_q     <= wb_tag_d;
      flush_done_q <= flush_done_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      age_q        <= age_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22040632_tag_array_assoc.sv
// tb_ysyx_22040632_tag_array_assoc: randomized scoreboard bench against a line-level reference model
module tb_ysyx_22040632_tag_array_assoc;
  localparam int WAYS = 4;
  localparam int SETS = 32;
  localparam int TAG_W = 21;
  localparam int IDX_W = 5;
  localparam int WAY_W = 2;

  logic clk = 1'b0, rst;
  logic [IDX_W-1:0] req_set, wb_set;
  logic [TAG_W-1:0] req_tag, victim_tag, wb_tag;
  logic lookup_en, hit, hit_dirty, victim_valid, victim_dirty, wr_en, wr_dirty, mark_dirty_en;
  logic flush_req, busy, wb_valid, wb_ready, flush_done;
  logic [WAY_W-1:0] hit_way, victim_way, wr_way, mark_way, wb_way;

  ysyx_22040632_tag_array_assoc dut (
    .clk(clk), .rst(rst), .req_set(req_set), .req_tag(req_tag), .lookup_en(lookup_en),
    .hit(hit), .hit_way(hit_way), .hit_dirty(hit_dirty), .victim_way(victim_way),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .wr_en(wr_en), .wr_way(wr_way), .wr_dirty(wr_dirty), .mark_dirty_en(mark_dirty_en),
    .mark_way(mark_way), .flush_req(flush_req), .busy(busy), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_set(wb_set), .wb_way(wb_way), .wb_tag(wb_tag), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic busy, full, wbz, wbv, done, hit, hit_dirty, vvalid, vdirty;
    logic [WAY_W-1:0] hit_way, vway, wway;
    logic [IDX_W-1:0] wset;
    logic [TAG_W-1:0] vtag, wtag;
  } exp_t;
  typedef struct {
    logic wbv, done, rdy;
    int s, w;
    logic [TAG_W-1:0] t;
  } sch_t;

  exp_t exp_q[$];
  sch_t sched[$];
  exp_t me;
  bit mv [SETS][WAYS];
  bit md [SETS][WAYS];
  logic [TAG_W-1:0] mt [SETS][WAYS];
  int ma [SETS][WAYS];
  bit m_wbz;
  int force_low = -1;
  int checks = 0, failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0; ma[s][w] = w;
      end
    sched.delete();
    m_wbz = 1;
  endfunction

  function automatic int m_hitway(int s, logic [TAG_W-1:0] t);
    for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int m_victim(int s);
    for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
    for (int w = 0; w < WAYS; w++) if (ma[s][w] == WAYS - 1) return w;
    return 0;
  endfunction

  function automatic void m_touch(int s, int w);
    int a = ma[s][w];
    for (int v = 0; v < WAYS; v++) if (ma[s][v] < a) ma[s][v]++;
    ma[s][w] = 0;
  endfunction

  function automatic void m_build();
    sch_t e;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        e = '{wbv: 0, done: 0, rdy: 1'($urandom_range(0, 1)), s: 0, w: 0, t: '0};
        sched.push_back(e);
        if (mv[s][w] && md[s][w]) begin
          int k = force_low >= 0 ? force_low : int'($urandom_range(0, 3));
          for (int i = 0; i <= k; i++) begin
            e = '{wbv: 1, done: 0, rdy: i == k, s: s, w: w, t: mt[s][w]};
            sched.push_back(e);
          end
        end
      end
    e = '{wbv: 0, done: 1, rdy: 1'($urandom_range(0, 1)), s: 0, w: 0, t: '0};
    sched.push_back(e);
    m_wbz = 0;
  endfunction

  function automatic void m_flushed();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0; md[s][w] = 0; ma[s][w] = w;
      end
  endfunction

  task automatic step();
    exp_t e;
    int hw = -1, v, s;
    e = '{default: '0};
    if (sched.size() > 0) begin
      e.busy = 1; e.wbv = sched[0].wbv; e.done = sched[0].done;
      e.wset = IDX_W'(sched[0].s); e.wway = WAY_W'(sched[0].w); e.wtag = sched[0].t;
      wb_ready = sched[0].rdy;
    end else begin
      s = int'(req_set);
      hw = m_hitway(s, req_tag);
      v = m_victim(s);
      e.full = 1; e.wbz = m_wbz; e.hit = hw >= 0;
      e.hit_way = hw >= 0 ? WAY_W'(hw) : '0;
      e.hit_dirty = hw >= 0 && md[s][hw];
      e.vway = WAY_W'(v); e.vvalid = mv[s][v]; e.vdirty = md[s][v]; e.vtag = mt[s][v];
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) m_reset();
    else if (sched.size() > 0) begin
      if (sched[0].done) m_flushed();
      void'(sched.pop_front());
    end else begin
      s = int'(req_set);
      if (wr_en) begin
        mv[s][wr_way] = 1; md[s][wr_way] = wr_dirty; mt[s][wr_way] = req_tag;
      end
      if (mark_dirty_en) md[s][mark_way] = 1;
      if (wr_en) m_touch(s, int'(wr_way));
      else if (mark_dirty_en) m_touch(s, int'(mark_way));
      else if (lookup_en && hw >= 0) m_touch(s, hw);
      if (flush_req) m_build();
    end
    #1;
  endtask

  task automatic clr_in();
    lookup_en = 0; wr_en = 0; wr_dirty = 0; mark_dirty_en = 0; flush_req = 0; wb_ready = 0;
  endtask

  task automatic drive(logic [IDX_W-1:0] s, logic [TAG_W-1:0] t, logic lk, logic we, logic [WAY_W-1:0] ww, logic wd, logic mk, logic [WAY_W-1:0] mw, logic fr);
    req_set = s; req_tag = t; lookup_en = lk; wr_en = we; wr_way = ww; wr_dirty = wd;
    mark_dirty_en = mk; mark_way = mw; flush_req = fr;
    step();
  endtask

  task automatic rnd(int fl_prob);
    int hw;
    req_set = $urandom_range(0, 1) == 1 ? IDX_W'($urandom_range(0, 3)) : IDX_W'($urandom);
    req_tag = TAG_W'(32'h10 + $urandom_range(0, 5));
    lookup_en = 1'($urandom_range(0, 1));
    wr_en = $urandom_range(0, 3) == 0;
    wr_dirty = 1'($urandom_range(0, 1));
    hw = m_hitway(int'(req_set), req_tag);
    wr_way = hw >= 0 ? WAY_W'(hw) : WAY_W'($urandom);
    mark_dirty_en = $urandom_range(0, 5) == 0;
    mark_way = WAY_W'($urandom);
    flush_req = fl_prob > 0 && $urandom_range(1, fl_prob) == 1;
    wb_ready = 1'($urandom_range(0, 1));
    step();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("busy", 32'(busy), 32'(me.busy));
      chk("wb_valid", 32'(wb_valid), 32'(me.wbv));
      chk("flush_done", 32'(flush_done), 32'(me.done));
      if (me.wbv) begin
        chk("wb_set", 32'(wb_set), 32'(me.wset));
        chk("wb_way", 32'(wb_way), 32'(me.wway));
        chk("wb_tag", 32'(wb_tag), 32'(me.wtag));
      end
      if (me.busy) chk("hit_while_busy", 32'(hit), 32'(0));
      if (me.full) begin
        chk("hit", 32'(hit), 32'(me.hit));
        chk("hit_way", 32'(hit_way), 32'(me.hit_way));
        chk("hit_dirty", 32'(hit_dirty), 32'(me.hit_dirty));
        chk("victim_way", 32'(victim_way), 32'(me.vway));
        chk("victim_valid", 32'(victim_valid), 32'(me.vvalid));
        chk("victim_dirty", 32'(victim_dirty), 32'(me.vdirty));
        chk("victim_tag", 32'(victim_tag), 32'(me.vtag));
        if (me.wbz) begin
          chk("wb_set_rst", 32'(wb_set), 32'(0));
          chk("wb_way_rst", 32'(wb_way), 32'(0));
          chk("wb_tag_rst", 32'(wb_tag), 32'(0));
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1; req_set = '0; req_tag = '0; wr_way = '0; mark_way = '0;
    clr_in();
    @(posedge clk);
    #1;
    m_reset();
    step();
    rst = 0;
    drive(3, 21'h1ABCD, 1, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < WAYS; w++) drive(5, TAG_W'(32'h10 + w), 0, 1, WAY_W'(w), 0, 0, 0, 0);
    drive(5, 21'h10, 1, 0, 0, 0, 0, 0, 0);
    drive(5, 21'h10, 0, 0, 0, 0, 0, 0, 0);
    drive(5, 21'h0, 0, 0, 0, 0, 1, 2, 0);
    drive(5, 21'h12, 1, 0, 0, 0, 0, 0, 0);
    drive(5, 21'h12, 0, 0, 0, 0, 0, 0, 0);
    force_low = 3;
    drive(5, 21'h12, 0, 0, 0, 0, 0, 0, 1);
    force_low = -1;
    n = 0;
    while (sched.size() > 0 && n < 4 * SETS * WAYS) begin
      drive(n % 3 == 0 ? 5 : 0, n % 3 == 0 ? 21'h12 : 21'h77, 1, 1, 0, 1, 1, 0, n % 17 == 5);
      n++;
    end
    drive(5, 21'h12, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 21'h77, 1, 0, 0, 0, 0, 0, 0);
    drive(7, 21'h15, 0, 1, 1, 1, 0, 0, 0);
    drive(9, 21'h16, 0, 1, 3, 1, 0, 0, 1);
    n = 0;
    while (!(sched.size() > 0 && sched[0].wbv) && n < 4 * SETS * WAYS) begin
      drive(7, 21'h15, 0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    rst = 1;
    drive(7, 21'h15, 0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    drive(7, 21'h15, 1, 0, 0, 0, 0, 0, 0);
    drive(9, 21'h16, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6000; i++) rnd(150);
    clr_in();
    n = 0;
    while (sched.size() > 0 && n < 4 * SETS * WAYS) begin
      step();
      n++;
    end
    for (int s = 0; s < 4; s++) drive(IDX_W'(s), 21'h11, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
